// File: rtl/csr_reg.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause plus 64-bit mcycle.
// Optional 64-bit instret counter is built when CSR_INSTRET_EN is defined.
module csr_reg #(
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_in,
  output logic [DATA_WIDTH-1:0]     csr_rdata_out,
  input  logic                      csr_we_in,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_in,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_in,
  input  logic                      clint_we_in,
  input  logic [CSR_ADDR_WIDTH-1:0] clint_waddr_in,
  input  logic [DATA_WIDTH-1:0]     clint_wdata_in,
  input  logic [CSR_ADDR_WIDTH-1:0] clint_raddr_in,
  output logic [DATA_WIDTH-1:0]     clint_rdata_out,
  input  logic                      inst_retire_in,
  output logic [DATA_WIDTH-1:0]     mtvec_out,
  output logic [DATA_WIDTH-1:0]     mepc_out,
  output logic [DATA_WIDTH-1:0]     mstatus_out,
  output logic                      global_int_en_out
);

  localparam int unsigned AW = CSR_ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = 2 * DATA_WIDTH;

  localparam logic [AW-1:0] A_MSTATUS   = AW'('h300);
  localparam logic [AW-1:0] A_MIE       = AW'('h304);
  localparam logic [AW-1:0] A_MTVEC     = AW'('h305);
  localparam logic [AW-1:0] A_MSCRATCH  = AW'('h340);
  localparam logic [AW-1:0] A_MEPC      = AW'('h341);
  localparam logic [AW-1:0] A_MCAUSE    = AW'('h342);
  localparam logic [AW-1:0] A_MCYCLE    = AW'('hB00);
  localparam logic [AW-1:0] A_MCYCLEH   = AW'('hB80);
  localparam logic [AW-1:0] A_CYCLE     = AW'('hC00);
  localparam logic [AW-1:0] A_CYCLEH    = AW'('hC80);
  localparam logic [AW-1:0] A_MINSTRET  = AW'('hB02);
  localparam logic [AW-1:0] A_MINSTRETH = AW'('hB82);
  localparam logic [AW-1:0] A_INSTRET   = AW'('hC02);
  localparam logic [AW-1:0] A_INSTRETH  = AW'('hC82);

  localparam logic [DW-1:0] MSTATUS_RST = DW'('h1800);
  localparam logic [DW-1:0] MSTATUS_WR  = DW'('h88);

  logic [DW-1:0] mstatus_q, mstatus_d;
  logic [DW-1:0] mie_q, mie_d;
  logic [DW-1:0] mtvec_q, mtvec_d;
  logic [DW-1:0] mscratch_q, mscratch_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic [DW-1:0] mcause_q, mcause_d;
  logic [CW-1:0] mcycle_q, mcycle_d;
  logic [CW-1:0] minstret_q, minstret_d;

  // Addresses that accept a write; read-only aliases and holes are excluded.
  function automatic logic writable(input logic [AW-1:0] addr);
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MCYCLEH:       writable = 1'b1;
`ifdef CSR_INSTRET_EN
      A_MINSTRET, A_MINSTRETH:   writable = 1'b1;
`endif
      default:                   writable = 1'b0;
    endcase
  endfunction

  // Value a register takes when written with data.
  function automatic logic [DW-1:0] wmask(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    case (addr)
      A_MSTATUS:      wmask = (data & MSTATUS_WR) | MSTATUS_RST;
      A_MTVEC, A_MEPC: wmask = data & ~DW'('h3);
      default:        wmask = data;
    endcase
  endfunction

  logic          clint_act, csr_act;
  logic [DW-1:0] clint_wval, csr_wval;

  // A same-address execute write is dropped in favour of the clint write.
  always_comb begin
    clint_act  = reset_n_in & clint_we_in & writable(clint_waddr_in);
    csr_act    = reset_n_in & csr_we_in & writable(csr_waddr_in)
                 & ~(clint_act & (clint_waddr_in == csr_waddr_in));
    clint_wval = wmask(clint_waddr_in, clint_wdata_in);
    csr_wval   = wmask(csr_waddr_in, csr_wdata_in);
  end

  logic [1:0][AW-1:0] rd_addr;
  logic [1:0][DW-1:0] rd_data;

  always_comb begin
    rd_addr[0] = csr_raddr_in;
    rd_addr[1] = clint_raddr_in;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      case (rd_addr[p])
        A_MSTATUS:           rd_data[p] = mstatus_q;
        A_MIE:               rd_data[p] = mie_q;
        A_MTVEC:             rd_data[p] = mtvec_q;
        A_MSCRATCH:          rd_data[p] = mscratch_q;
        A_MEPC:              rd_data[p] = mepc_q;
        A_MCAUSE:            rd_data[p] = mcause_q;
        A_MCYCLE, A_CYCLE:   rd_data[p] = mcycle_q[DW-1:0];
        A_MCYCLEH, A_CYCLEH: rd_data[p] = mcycle_q[CW-1:DW];
`ifdef CSR_INSTRET_EN
        A_MINSTRET, A_INSTRET:   rd_data[p] = minstret_q[DW-1:0];
        A_MINSTRETH, A_INSTRETH: rd_data[p] = minstret_q[CW-1:DW];
`endif
        default:             rd_data[p] = '0;
      endcase
      if (csr_act && (csr_waddr_in == rd_addr[p]))
        rd_data[p] = csr_wval;
      if (clint_act && (clint_waddr_in == rd_addr[p]))
        rd_data[p] = clint_wval;
    end
  end

  assign csr_rdata_out   = rd_data[0];
  assign clint_rdata_out = rd_data[1];

  logic [1:0]         wr_act;
  logic [1:0][AW-1:0] wr_addr;
  logic [1:0][DW-1:0] wr_val;
  logic               cyc_wr, ret_wr;

  // Next-state: execute port applied first, clint second so it takes precedence.
  always_comb begin
    wr_act     = {clint_act, csr_act};
    wr_addr    = {clint_waddr_in, csr_waddr_in};
    wr_val     = {clint_wval, csr_wval};
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    cyc_wr     = 1'b0;
    ret_wr     = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (wr_act[p]) begin
        case (wr_addr[p])
          A_MSTATUS:   mstatus_d  = wr_val[p];
          A_MIE:       mie_d      = wr_val[p];
          A_MTVEC:     mtvec_d    = wr_val[p];
          A_MSCRATCH:  mscratch_d = wr_val[p];
          A_MEPC:      mepc_d     = wr_val[p];
          A_MCAUSE:    mcause_d   = wr_val[p];
          A_MCYCLE:    begin mcycle_d[DW-1:0]    = wr_val[p]; cyc_wr = 1'b1; end
          A_MCYCLEH:   begin mcycle_d[CW-1:DW]   = wr_val[p]; cyc_wr = 1'b1; end
          A_MINSTRET:  begin minstret_d[DW-1:0]  = wr_val[p]; ret_wr = 1'b1; end
          A_MINSTRETH: begin minstret_d[CW-1:DW] = wr_val[p]; ret_wr = 1'b1; end
          default:     ;
        endcase
      end
    end
    if (!cyc_wr)
      mcycle_d = mcycle_q + CW'(1);
    if (!ret_wr)
      minstret_d = minstret_q + CW'(inst_retire_in);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

`ifdef CSR_INSTRET_EN
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) minstret_q <= '0;
    else             minstret_q <= minstret_d;
  end
`else
  // Counter is not built; its next-state logic is left dangling and trimmed.
  assign minstret_q = '0;
  logic unused_instret;
  assign unused_instret = ^{minstret_d, inst_retire_in};
`endif

  assign mtvec_out         = mtvec_q;
  assign mepc_out          = mepc_q;
  assign mstatus_out       = mstatus_q;
  assign global_int_en_out = mstatus_q[3];

endmodule

// File: doc/csr_reg.md
# csr_reg

Machine-mode control and status register file for the RV32 core. It answers the CSR addresses that the decode stage produces, and takes write-back from the execute stage. A second, higher-priority port lets the trap/interrupt controller (clint) save and restore trap state. It also owns the 64-bit cycle counter, an optional instruction-retire counter, and the trap-related values the fetch and control logic need.

## Interface
- `CSR_ADDR_WIDTH`, 12, CSR address width.
- `DATA_WIDTH`, 32, CSR data width.
- `clk_in` input 1: clock.
- `reset_n_in` input 1: reset. Synchronous and active-low.
- `csr_raddr_in` input 12: read address from the decode stage.
- `csr_rdata_out` output 32: read data to the decode stage. Combinational.
- `csr_we_in` input 1: write enable from the execute stage.
- `csr_waddr_in` input 12: execute-stage write address.
- `csr_wdata_in` input 32: execute-stage write data.
- `clint_we_in` input 1: write enable from the trap controller.
- `clint_waddr_in` input 12: trap-controller write address.
- `clint_wdata_in` input 32: trap-controller write data.
- `clint_raddr_in` input 12: trap-controller read address.
- `clint_rdata_out` output 32: trap-controller read data. Combinational.
- `inst_retire_in` input 1: one pulse per retired instruction. Used only with `CSR_INSTRET_EN`.
- `mtvec_out` output 32: current mtvec.
- `mepc_out` output 32: current mepc.
- `mstatus_out` output 32: current mstatus.
- `global_int_en_out` output 1: equals mstatus[3] (MIE).

## Operation
Implemented registers:
- mstatus 0x300:
  - Only MIE [3] and MPIE [7] are writable.
  - MPP [12:11] is hardwired to 2'b11.
  - All other bits read 0.
- mie 0x304: full 32-bit read/write.
- mtvec 0x305: bits [1:0] forced to 0 (direct mode only).
- mscratch 0x340: full 32-bit read/write.
- mepc 0x341: bits [1:0] forced to 0.
- mcause 0x342: full 32-bit read/write.
- mcycle 0xB00 / mcycleh 0xB80: read/write halves of the 64-bit cycle counter.
- cycle 0xC00 / cycleh 0xC80: read-only aliases of mcycle. Writes to them are ignored.

Unimplemented addresses read 0, and writes to them are dropped.

Write ports:
- Both ports write on the rising edge.
- Same address on both ports in the same cycle: the clint write wins and the execute write is discarded.
- Different addresses: both writes happen in the same cycle.

Read bypass:
- Applies to each read port independently.
- If the read address equals an active write address this cycle, the port returns the write data after the target register's mask is applied.
- When both write ports hit the read address, the clint data is returned.
- Otherwise the port returns the stored value.

Cycle counter:
- 64-bit; increments by 1 every cycle that reset is not asserted.
- Wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to one half loads that half with the write data in that cycle; the increment is suppressed for that cycle only.
- Reading a counter returns the pre-increment registered value; the bypass rule takes precedence.

## Timing
- Reads have zero latency, from address to data, on both ports.
- Writes become visible in the stored value one cycle after the write edge. The bypass rule covers the write cycle itself.
- `mtvec_out`, `mepc_out`, `mstatus_out` and `global_int_en_out` come directly from the registers. They change on the edge after a write, with no bypass.
- Reset is sampled on `clk_in`. When `reset_n_in` = 0 at an edge, all registers load their reset values:
  - mstatus = 0x0000_1800.
  - All other registers, including both counters, = 0.
- Writes and increments are blocked in any cycle that reset is asserted.
- Reset asserted mid-operation takes priority over any concurrent write or increment.
- Output values after reset: `mstatus_out` = 0x1800, `mtvec_out` = 0, `mepc_out` = 0, `global_int_en_out` = 0. With idle inputs and read addresses of 0, both `*_rdata_out` = 0.

## Configuration
- `CSR_INSTRET_EN` defined:
  - Adds a 64-bit instret counter.
  - Read/write at minstret 0xB02 / minstreth 0xB82.
  - Read-only aliases at 0xC02 / 0xC82.
  - Increments by 1 on each cycle where `inst_retire_in` = 1.
  - Uses the same wrap, write-override and bypass rules as mcycle.
- `CSR_INSTRET_EN` not defined:
  - No counter logic is built and `inst_retire_in` is ignored.
  - The four instret addresses read 0 and writes to them are dropped.

## Test plan
- Reset then idle: hold `reset_n_in` = 0 for 2 cycles, release, wait 10 cycles → reading 0xB00 returns 10 (±0 against the bench's cycle model), 0xB80 returns 0, and 0x300 returns 0x1800.
- Masking: execute writes 0xFFFF_FFFF to 0x300, then to 0x305, then to 0x341 → stored values read back 0x1888, 0xFFFF_FFFC and 0xFFFF_FFFC; `global_int_en_out` = 1 on the edge after the mstatus write.
- Port collision: in the same cycle, execute writes 0x1111_1111 and clint writes 0x2222_2222, both to 0x340 → the read returns 0x2222_2222 in that cycle and in the next one.
- Bypass and wrap:
  - Write 0xFFFF_FFFF to 0xB00 and to 0xB80 → while each write is active, the bypass returns the write data.
  - Two cycles after the last write → counter reads 0x0000_0000_0000_0000 (post-wrap).
  - Write 0x5 to 0xC00 → ignored.
- Reset mid-write: assert reset in the same cycle as a clint write of 0xDEAD_BEEC to 0x341 → mepc = 0 afterwards.
- With `CSR_INSTRET_EN`: pulse `inst_retire_in` 7 times within 20 cycles → 0xC02 reads 7. Without the macro, 0xC02 reads 0.
